// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - shared types and constants for the APB requester
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  localparam int unsigned DEFAULT_APB_TIMEOUT = 256;

endpackage

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB4 requester: valid/ready request in, APB transfer, valid/ready response out
module apb_requester
  import apb_uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_APB_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Abort fires on the ACCESS cycle whose increment would reach the limit.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  apb_req_state_e          state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = req_addr_i;
          pwrite_d  = req_we_i;
          pwdata_d  = req_we_i ? req_wdata_i : '0;
          pstrb_d   = req_we_i ? req_strb_i : '0;
          cnt_d     = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (pready_i) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
        end else if (timeout_hit) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign busy_o        = (state_q != IDLE);
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester with a transaction-level reference model
module tb_apb_requester;

  localparam int T = 8;

  logic        clk_i;
  logic        arst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic        psel_o;
  logic        penable_o;
  logic [4:0]  paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int checks = 0;
  int errors = 0;

  apb_requester #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One transfer, expected behaviour derived from the transaction parameters:
  // the slave answers after `waits` wait states, unless that exceeds the timeout.
  task automatic run_xfer(input logic [4:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                          input logic slverr, input int rsp_delay, input bit hold);
    bit          to;
    int          alen;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [41:0] exp_apb;
    to        = (waits >= T);
    alen      = to ? T : waits + 1;
    exp_rdata = (to || we) ? 32'h0 : rdata;
    exp_err   = to | slverr;
    exp_apb   = {addr, we, (we ? strb : 4'h0), (we ? wdata : 32'h0)};

    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b expected 1", req_ready_o);
    end
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
    req_wdata_i = wdata; req_strb_i = strb;
    @(negedge clk_i);
    if (!hold) begin
      req_valid_i = 1'b0; req_addr_i = 5'($urandom); req_we_i = 1'($urandom);
      req_wdata_i = $urandom; req_strb_i = 4'($urandom);
    end
    pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);

    checks++;
    if ({psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pstrb_o, pwdata_o} !== {3'b100, exp_apb}) begin
      errors++;
      $display("FAIL setup_phase: got %h expected %h",
               {psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pstrb_o, pwdata_o}, {3'b100, exp_apb});
    end

    for (int n = 1; n <= alen; n++) begin
      @(negedge clk_i);
      checks++;
      if ({psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pstrb_o, pwdata_o} !== {3'b110, exp_apb}) begin
        errors++;
        $display("FAIL access_phase[%0d]: got %h expected %h", n,
                 {psel_o, penable_o, rsp_valid_o, paddr_o, pwrite_o, pstrb_o, pwdata_o}, {3'b110, exp_apb});
      end
      if (!to && n == waits + 1) begin
        pready_i = 1'b1; prdata_i = rdata; pslverr_i = slverr;
      end else begin
        pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom);
      end
    end
    @(negedge clk_i);

    for (int d = 0; d <= rsp_delay; d++) begin
      pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
      checks++;
      if ({psel_o, penable_o, req_ready_o, rsp_valid_o, busy_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, paddr_o, pwrite_o, pstrb_o, pwdata_o}
          !== {5'b00011, exp_err, to, exp_rdata, exp_apb}) begin
        errors++;
        $display("FAIL resp_phase[%0d]: got %h expected %h", d,
                 {psel_o, penable_o, req_ready_o, rsp_valid_o, busy_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o, paddr_o, pwrite_o, pstrb_o, pwdata_o},
                 {5'b00011, exp_err, to, exp_rdata, exp_apb});
      end
      rsp_ready_i = (d == rsp_delay);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;

    checks++;
    if ({rsp_valid_o, req_ready_o, busy_o, psel_o, penable_o} !== 5'b01000) begin
      errors++;
      $display("FAIL return_idle: got %b expected 01000",
               {rsp_valid_o, req_ready_o, busy_o, psel_o, penable_o});
    end
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0; req_wdata_i = '0; req_strb_i = '0;
    rsp_ready_i = 1'b0; pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({psel_o, penable_o, rsp_valid_o, busy_o, req_ready_o, paddr_o, pwrite_o, pstrb_o, pwdata_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}
        !== {5'b00001, 42'h0, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h",
               {psel_o, penable_o, rsp_valid_o, busy_o, req_ready_o, paddr_o, pwrite_o, pstrb_o, pwdata_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o},
               {5'b00001, 42'h0, 2'b00, 32'h0});
    end
    arst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_write();
    run_xfer(5'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_read_wait();
    run_xfer(5'h08, 1'b0, 32'hCAFEF00D, 4'hF, 3, 32'h12345678, 1'b0, 0, 1'b0);
  endtask

  task automatic test_slverr();
    run_xfer(5'h1C, 1'b0, 32'h0, 4'h0, 0, 32'hA5A50F0F, 1'b1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer(5'h10, 1'b0, 32'h0, 4'h0, 30, 32'h11111111, 1'b0, 1, 1'b0);
    run_xfer(5'h10, 1'b0, 32'h0, 4'h0, T - 1, 32'h22222222, 1'b0, 0, 1'b0);
    run_xfer(5'h14, 1'b1, 32'h33333333, 4'h5, T, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer(5'h0C, 1'b1, 32'h0BADCAFE, 4'h3, 1, 32'h0, 1'b0, 5, 1'b1);
    run_xfer(5'h0C, 1'b1, 32'h0BADCAFE, 4'h3, 0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_xfer(5'($urandom), 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 11)),
               $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1; req_addr_i = 5'h18; req_we_i = 1'b1; req_wdata_i = 32'h55AA55AA; req_strb_i = 4'hF;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    pready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 arst_ni = 1'b0;
    #1;
    checks++;
    if ({psel_o, penable_o, rsp_valid_o, busy_o, req_ready_o, paddr_o, pwdata_o} !== {5'b00001, 5'h0, 32'h0}) begin
      errors++;
      $display("FAIL async_reset_mid: got %h expected %h",
               {psel_o, penable_o, rsp_valid_o, busy_o, req_ready_o, paddr_o, pwdata_o}, {5'b00001, 5'h0, 32'h0});
    end
    @(negedge clk_i);
    arst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pready_i = 1'($urandom); rsp_ready_i = 1'($urandom);
      @(negedge clk_i);
      checks++;
      if ({rsp_valid_o, psel_o, req_ready_o} !== 3'b001) begin
        errors++;
        $display("FAIL post_reset_quiet[%0d]: got %b expected 001", c, {rsp_valid_o, psel_o, req_ready_o});
      end
    end
    rsp_ready_i = 1'b0;
    run_xfer(5'h02, 1'b0, 32'h0, 4'h0, 2, 32'h0F0F1234, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
